pi_req_queue: RTL and testbench

PI_REQ_QUEUE -- requirements
Module: pi_req_queue

---
 rtl/pi_req_queue.sv | 158 +++++++++++++++
 tb/tb_pi_req_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_req_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pi_req_queue                                                   |
// | Brief   : Pi register-write decoder feeding a bus-request FIFO with a    |
// |           registered head, in-flight tracking and busy indication.       |
// |           Define PI_REQ_QUEUE_OVF_EN to enable the sticky overflow flag. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pi_req_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   pi_wr_falling,
  input  logic [2:0]             pi_a,
  input  logic [15:0]            pi_data_in,
  output logic                   q_valid,
  input  logic                   q_ready,
  output logic [23:0]            q_addr,
  output logic [1:0]             q_size,
  output logic                   q_read,
  output logic [2:0]             q_fc,
  output logic [31:0]            q_data,
  input  logic                   q_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_ew = 62;  // {fc, read, size, addr, data}
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);

  logic [c_ew-1:0] r_mem [DEPTH];
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_cw-1:0] r_count;
  logic            r_q_valid;
  logic [c_ew-1:0] r_head;
  logic            r_inflight;
  logic            r_busy;
  logic [15:0]     r_data_lo;
  logic [15:0]     r_data_hi;
  logic [15:0]     r_addr_lo;

  logic            w_commit;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic [c_cw-1:0] w_remain;
  logic [c_cw-1:0] w_count_nxt;
  logic [c_aw-1:0] w_rd_nxt;
  logic [c_ew-1:0] w_new_entry;
  logic [c_ew-1:0] w_head_nxt;
  logic            w_inflight_nxt;

  assign w_commit    = pi_wr_falling && (pi_a == 3'd3);
  assign w_full      = (r_count == c_depth);
  assign w_pop       = r_q_valid && q_ready;
  assign w_push      = w_commit && (!w_full || w_pop);
  assign w_remain    = w_pop ? (r_count - c_cnt_one) : r_count;
  assign w_count_nxt = w_push ? (w_remain + c_cnt_one) : w_remain;
  assign w_rd_nxt    = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
  assign w_new_entry = {pi_data_in[13:11], pi_data_in[10], pi_data_in[9:8],
                        pi_data_in[7:0], r_addr_lo, r_data_hi, r_data_lo};

  // The head register reloads from the new commit when nothing older survives
  // this cycle, otherwise from the next stored entry after a pop.
  always_comb begin
    w_head_nxt = r_head;
    if (w_push && (w_remain == '0)) begin
      w_head_nxt = w_new_entry;
    end else if (w_pop && (w_remain != '0)) begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // A done in the pop cycle belongs to the previous entry, so pop wins.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_pop) begin
      w_inflight_nxt = 1'b1;
    end else if (q_done) begin
      w_inflight_nxt = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new_entry;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_q_valid  <= 1'b0;
      r_head     <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_data_lo  <= '0;
      r_data_hi  <= '0;
      r_addr_lo  <= '0;
    end else begin
      r_rd_ptr   <= w_rd_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      r_count    <= w_count_nxt;
      r_q_valid  <= (w_count_nxt != '0);
      r_head     <= w_head_nxt;
      r_inflight <= w_inflight_nxt;
      r_busy     <= (w_count_nxt != '0) || w_inflight_nxt;
      if (pi_wr_falling) begin
        case (pi_a)
          3'd0:    r_data_lo <= pi_data_in;
          3'd1:    r_data_hi <= pi_data_in;
          3'd2:    r_addr_lo <= pi_data_in;
          default: ;
        endcase
      end
    end
  end

`ifdef PI_REQ_QUEUE_OVF_EN
  logic r_ovf;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ovf <= 1'b0;
    end else if (w_commit && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (pi_wr_falling && (pi_a == 3'd5)) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign q_valid = r_q_valid;
  assign {q_fc, q_read, q_size, q_addr, q_data} = r_head;
  assign busy    = r_busy;
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_pi_req_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pi_req_queue                                                |
// | Brief   : Self-checking bench for pi_req_queue (table, corners, random). |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pi_req_queue;

  localparam int DEPTH = 4;
`ifdef PI_REQ_QUEUE_OVF_EN
  localparam bit c_ovf_en = 1'b1;
`else
  localparam bit c_ovf_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pi_wr_falling;
  logic [2:0]  pi_a;
  logic [15:0] pi_data_in;
  logic        q_valid;
  logic        q_ready;
  logic [23:0] q_addr;
  logic [1:0]  q_size;
  logic        q_read;
  logic [2:0]  q_fc;
  logic [31:0] q_data;
  logic        q_done;
  logic        busy;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  pi_req_queue #(.DEPTH(DEPTH)) dut (
    .sys_clk       (clk),
    .sys_rst       (rst),
    .pi_wr_falling (pi_wr_falling),
    .pi_a          (pi_a),
    .pi_data_in    (pi_data_in),
    .q_valid       (q_valid),
    .q_ready       (q_ready),
    .q_addr        (q_addr),
    .q_size        (q_size),
    .q_read        (q_read),
    .q_fc          (q_fc),
    .q_data        (q_data),
    .q_done        (q_done),
    .busy          (busy),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of decoded requests plus a few status bits.
  typedef struct {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        read;
    logic [2:0]  fc;
    logic [31:0] data;
  } entry_t;

  entry_t      mq[$];
  bit          m_inflight;
  bit          m_ovf;
  logic [15:0] m_lo, m_hi, m_alo;

  typedef struct {
    bit        wr;
    bit [2:0]  a;
    bit [15:0] d;
    bit        rdy;
    bit        done;
    bit        e_valid;
    bit [2:0]  e_count;
    bit        e_busy;
    bit [23:0] e_addr;
    bit [1:0]  e_size;
    bit        e_read;
    bit [2:0]  e_fc;
    bit [31:0] e_data;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_inflight = 1'b0;
    m_ovf      = 1'b0;
    m_lo       = '0;
    m_hi       = '0;
    m_alo      = '0;
  endtask

  task automatic model_step(input bit wr, input bit [2:0] a, input bit [15:0] d,
                            input bit rdy, input bit done);
    entry_t e;
    bit pop, was_full, ovf_set;
    pop      = (mq.size() > 0) && rdy;
    was_full = (mq.size() == DEPTH);
    ovf_set  = 1'b0;
    e.addr = {d[7:0], m_alo};
    e.size = d[9:8];
    e.read = d[10];
    e.fc   = d[13:11];
    e.data = {m_hi, m_lo};
    if (pop) void'(mq.pop_front());
    if (pop) m_inflight = 1'b1;
    else if (done) m_inflight = 1'b0;
    if (wr && a == 3'd3) begin
      if (!was_full || pop) mq.push_back(e);
      else ovf_set = c_ovf_en;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (wr && a == 3'd5) m_ovf = 1'b0;
    if (wr && a == 3'd0) m_lo = d;
    if (wr && a == 3'd1) m_hi = d;
    if (wr && a == 3'd2) m_alo = d;
  endtask

  task automatic compare_model();
    chk("q_valid", 32'(q_valid), 32'(mq.size() > 0));
    chk("count", 32'(count), mq.size());
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("busy", 32'(busy), 32'((mq.size() > 0) || m_inflight));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (mq.size() > 0) begin
      chk("q_addr", 32'(q_addr), 32'(mq[0].addr));
      chk("q_size", 32'(q_size), 32'(mq[0].size));
      chk("q_read", 32'(q_read), 32'(mq[0].read));
      chk("q_fc", 32'(q_fc), 32'(mq[0].fc));
      chk("q_data", q_data, mq[0].data);
    end
  endtask

  // One clock: drive inputs, advance model and DUT, compare after the edge.
  task automatic cyc(input bit wr, input bit [2:0] a, input bit [15:0] d,
                     input bit rdy, input bit done);
    pi_wr_falling = wr;
    pi_a          = a;
    pi_data_in    = d;
    q_ready       = rdy;
    q_done        = done;
    model_step(wr, a, d, rdy, done);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(q_valid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_addr"}, 32'(q_addr), 32'd0);
    chk({tag, "_data"}, q_data, 32'd0);
    chk({tag, "_fields"}, 32'({q_fc, q_read, q_size}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pi_wr_falling = 1'b0; pi_a = '0; pi_data_in = '0;
    q_ready = 1'b0; q_done = 1'b0;
    model_reset();

    vt[0]  = '{1'b1, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'h0,      2'd0, 1'b0, 3'd0, 32'h0};
    vt[1]  = '{1'b1, 3'd1, 16'hABCD, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'h0,      2'd0, 1'b0, 3'd0, 32'h0};
    vt[2]  = '{1'b1, 3'd2, 16'h0010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'h0,      2'd0, 1'b0, 3'd0, 32'h0};
    vt[3]  = '{1'b1, 3'd3, 16'h0AFC, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 24'hFC0010, 2'd2, 1'b0, 3'd1, 32'hABCD1234};
    vt[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 24'hFC0010, 2'd2, 1'b0, 3'd1, 32'hABCD1234};
    vt[5]  = '{1'b1, 3'd3, 16'h0B05, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 24'hFC0010, 2'd2, 1'b0, 3'd1, 32'hABCD1234};
    vt[6]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 24'h050010, 2'd3, 1'b0, 3'd1, 32'hABCD1234};
    vt[7]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 24'h0,      2'd0, 1'b0, 3'd0, 32'h0};
    vt[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'h0,      2'd0, 1'b0, 3'd0, 32'h0};
    vt[9]  = '{1'b1, 3'd3, 16'h0400, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 24'h000010, 2'd0, 1'b1, 3'd0, 32'hABCD1234};
    vt[10] = '{1'b1, 3'd3, 16'h3801, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 24'h010010, 2'd0, 1'b0, 3'd7, 32'hABCD1234};
    vt[11] = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 24'h0,      2'd0, 1'b0, 3'd0, 32'h0};
    vt[12] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'h0,      2'd0, 1'b0, 3'd0, 32'h0};

    #2;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].wr, vt[i].a, vt[i].d, vt[i].rdy, vt[i].done);
      chk($sformatf("tbl%0d_valid", i), 32'(q_valid), 32'(vt[i].e_valid));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(vt[i].e_count));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      if (vt[i].e_valid) begin
        chk($sformatf("tbl%0d_addr", i), 32'(q_addr), 32'(vt[i].e_addr));
        chk($sformatf("tbl%0d_size", i), 32'(q_size), 32'(vt[i].e_size));
        chk($sformatf("tbl%0d_read", i), 32'(q_read), 32'(vt[i].e_read));
        chk($sformatf("tbl%0d_fc", i), 32'(q_fc), 32'(vt[i].e_fc));
        chk($sformatf("tbl%0d_data", i), q_data, vt[i].e_data);
      end
    end

    // Fill to full, fifth commit dropped, then clear overflow
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'd3, 16'(16'h0100 + i), 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf", 32'(ovf), 32'(c_ovf_en));
    cyc(1'b1, 3'd5, 16'h0000, 1'b0, 1'b0);
    chk("ovf_clear", 32'(ovf), 32'd0);

    // Commit and pop together while full
    cyc(1'b1, 3'd3, 16'h00EE, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("fullpp_last", 32'(q_addr[23:16]), 32'hEE);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);

    // Alternate push/pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 3'd3, 16'(16'h0020 + i), 1'b0, 1'b0);
      chk("alt_addr", 32'(q_addr[23:16]), 32'(8'h20 + 8'(i)));
      chk("alt_cnt_le1", 32'(count <= 3'd1), 32'd1);
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
      chk("alt_cnt_le1", 32'(count <= 3'd1), 32'd1);
    end

    // Long in-flight hold
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 3'd3, 16'h0033, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_empty", 32'(empty), 32'd1);
    end
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    chk("done_busy", 32'(busy), 32'd0);

    // Asynchronous reset with queued and in-flight entries
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'd3, 16'(16'h0040 + i), 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    pi_wr_falling = 1'b0; q_ready = 1'b0; q_done = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
      chk("post_rst_valid", 32'(q_valid), 32'd0);
    end
    cyc(1'b1, 3'd3, 16'h0155, 1'b0, 1'b0);
    chk("post_rst_data", q_data, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit [2:0] a;
      a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      cyc(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
